// File: rtl/tlp_play_pkg.sv
// tlp_play_pkg: register map, CTRL bit positions, table entry width and
// playback FSM state type shared by the TLP playback generator files.
package tlp_play_pkg;

  localparam logic [11:0] CTRL_ADDR  = 12'h000;
  localparam logic [11:0] LEN_ADDR   = 12'h004;
  localparam logic [11:0] FLAGS_BASE = 12'h400;
  localparam logic [11:0] DATA_BASE  = 12'h800;

  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;

  // Table entry layout: [65] eop, [64] sop, [63:32] data hi, [31:0] data lo.
  localparam int ENTRY_W = 66;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } play_state_t;

endpackage

// File: rtl/tlp_play_ram.sv
// tlp_play_ram: simple dual-port table RAM, DEPTH x 66 bits, one write port
// with separate lane enables for data lo, data hi and flags, one synchronous
// read port.
module tlp_play_ram
  import tlp_play_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_lo,
  input  logic               we_hi,
  input  logic               we_flg,
  input  logic [AW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Lane-masked write and registered read.
  always_ff @(posedge clk) begin
    if (we_lo)  mem[wr_addr][31:0]  <= wr_data[31:0];
    if (we_hi)  mem[wr_addr][63:32] <= wr_data[63:32];
    if (we_flg) mem[wr_addr][65:64] <= wr_data[65:64];
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tlp_play_gen.sv
// tlp_play_gen: replays a software-loaded table of 64-bit beats with SOP/EOP
// flags onto an Avalon-ST style source, once or continuously.
// Optional feature macro: TLP_PLAY_STATS_EN (accepted-EOP counter on tlp_cnt;
// when undefined tlp_cnt is tied to zero).
module tlp_play_gen
  import tlp_play_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        trn_clk,
  input  logic        trn_rst,
  input  logic        ip_wreq,
  input  logic [11:0] ip_wraddr,
  input  logic [31:0] ip_wrdata,
  input  logic        st_ready0,
  output logic        st_valid0,
  output logic        st_sop0,
  output logic        st_eop0,
  output logic [63:0] st_data0,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [15:0] tlp_cnt
);

  play_state_t state, state_nx;

  logic [AW-1:0]      ptr;
  logic [AW:0]        len;
  logic               loop_r;
  logic               stop_pend;

  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_q;

  logic               ctrl_wr, start_wr, stop_wr, len_wr, len_bad;
  logic               hs, finish, accept, reject;
  logic [AW:0]        inc1, inc2;
  logic [AW-1:0]      p1, p2;

  // Table write decode
  logic [7:0]         flg_idx, dat_idx;
  logic               flg_hit, dat_hit, tab_wr_ok;
  logic [AW-1:0]      wr_addr;

  assign flg_idx   = ip_wraddr[9:2];
  assign dat_idx   = ip_wraddr[10:3];
  assign flg_hit   = (ip_wraddr[11:10] == FLAGS_BASE[11:10]) && (ip_wraddr[1:0] == 2'b00)
                     && ({1'b0, flg_idx} < 9'(DEPTH));
  assign dat_hit   = (ip_wraddr[11] == DATA_BASE[11]) && (ip_wraddr[1:0] == 2'b00)
                     && ({1'b0, dat_idx} < 9'(DEPTH));
  assign tab_wr_ok = ip_wreq && !busy;
  assign wr_addr   = flg_hit ? flg_idx[AW-1:0] : dat_idx[AW-1:0];

  tlp_play_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (trn_clk),
    .we_lo   (tab_wr_ok && dat_hit && !ip_wraddr[2]),
    .we_hi   (tab_wr_ok && dat_hit &&  ip_wraddr[2]),
    .we_flg  (tab_wr_ok && flg_hit),
    .wr_addr (wr_addr),
    .wr_data ({ip_wrdata[1:0], ip_wrdata, ip_wrdata}),
    .rd_addr (rd_addr),
    .rd_data (rd_q)
  );

  assign ctrl_wr  = ip_wreq && (ip_wraddr == CTRL_ADDR);
  assign start_wr = ctrl_wr && ip_wrdata[CTRL_START];
  assign stop_wr  = ctrl_wr && ip_wrdata[CTRL_STOP];
  assign len_wr   = ip_wreq && (ip_wraddr == LEN_ADDR) && !busy;
  assign len_bad  = (len == '0) || (len > (AW+1)'(DEPTH));
  assign busy     = (state != IDLE);
  assign hs       = st_valid0 && st_ready0;

  // Modulo-LEN successors of ptr; p2 derived from p1 so LEN=1 also wraps right.
  always_comb begin
    inc1 = {1'b0, ptr} + (AW+1)'(1);
    p1   = (inc1 >= len) ? '0 : inc1[AW-1:0];
    inc2 = {1'b0, p1} + (AW+1)'(1);
    p2   = (inc2 >= len) ? '0 : inc2[AW-1:0];
  end

  // A handshake ends playback on an EOP once stop is pending, or at the last
  // entry unless looping without a pending stop.
  assign finish = hs && ((stop_pend && st_eop0) ||
                         ((inc1 == len) && !(loop_r && !stop_pend)));

  // State register.
  always_ff @(posedge trn_clk or posedge trn_rst) begin
    if (trn_rst) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state, start qualification and prefetch address.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    rd_addr  = '0;
    unique case (state)
      IDLE: begin
        if (start_wr) begin
          if (len_bad) reject = 1'b1;
          else begin
            accept   = 1'b1;
            state_nx = PRIME;
          end
        end
      end
      PRIME: begin
        rd_addr  = p1;
        state_nx = RUN;
      end
      RUN: begin
        rd_addr = hs ? p2 : p1;
        if (finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control registers, pointer, status pulses and the output beat register.
  always_ff @(posedge trn_clk or posedge trn_rst) begin
    if (trn_rst) begin
      ptr       <= '0;
      len       <= '0;
      loop_r    <= 1'b0;
      stop_pend <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      st_valid0 <= 1'b0;
      st_sop0   <= 1'b0;
      st_eop0   <= 1'b0;
      st_data0  <= '0;
    end else begin
      done    <= (state == RUN) && finish;
      cfg_err <= reject;
      if (ctrl_wr) loop_r <= ip_wrdata[CTRL_LOOP];
      if (len_wr)  len    <= ip_wrdata[AW:0];

      if (accept || finish)    stop_pend <= 1'b0;
      else if (stop_wr && busy) stop_pend <= 1'b1;

      if (accept) ptr <= '0;
      else if ((state == RUN) && hs && !finish) ptr <= p1;

      if ((state == PRIME) || ((state == RUN) && hs && !finish)) begin
        st_valid0 <= 1'b1;
        st_eop0   <= rd_q[65];
        st_sop0   <= rd_q[64];
        st_data0  <= rd_q[63:0];
      end else if ((state == RUN) && finish) begin
        st_valid0 <= 1'b0;
        st_eop0   <= 1'b0;
        st_sop0   <= 1'b0;
        st_data0  <= '0;
      end
    end
  end

`ifdef TLP_PLAY_STATS_EN
  // Accepted-EOP counter, cleared by an accepted start.
  always_ff @(posedge trn_clk or posedge trn_rst) begin
    if (trn_rst)               tlp_cnt <= '0;
    else if (accept)           tlp_cnt <= '0;
    else if (hs && st_eop0)    tlp_cnt <= tlp_cnt + 16'd1;
  end
`else
  assign tlp_cnt = '0;
`endif

endmodule

// File: tb/tb_tlp_play_gen.sv
// tb_tlp_play_gen: directed bench for tlp_play_gen.
module tb_tlp_play_gen;

  localparam int DEPTH = 64;

  logic        trn_clk = 1'b0;
  logic        trn_rst = 1'b1;
  logic        ip_wreq = 1'b0;
  logic [11:0] ip_wraddr = '0;
  logic [31:0] ip_wrdata = '0;
  logic        st_ready0 = 1'b0;
  logic        st_valid0, st_sop0, st_eop0, busy, done, cfg_err;
  logic [63:0] st_data0;
  logic [15:0] tlp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_data [4];
  logic [1:0]  exp_flg  [4];

  tlp_play_gen #(.DEPTH(DEPTH)) dut (
    .trn_clk   (trn_clk),
    .trn_rst   (trn_rst),
    .ip_wreq   (ip_wreq),
    .ip_wraddr (ip_wraddr),
    .ip_wrdata (ip_wrdata),
    .st_ready0 (st_ready0),
    .st_valid0 (st_valid0),
    .st_sop0   (st_sop0),
    .st_eop0   (st_eop0),
    .st_data0  (st_data0),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .tlp_cnt   (tlp_cnt)
  );

  always #5 trn_clk = ~trn_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef TLP_PLAY_STATS_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  task automatic tick;
    @(posedge trn_clk);
    #1;
  endtask

  task automatic reg_wr(input logic [11:0] addr, input logic [31:0] data);
    ip_wreq   = 1'b1;
    ip_wraddr = addr;
    ip_wrdata = data;
    tick();
    ip_wreq   = 1'b0;
  endtask

  task automatic load_entry(input int i, input logic [63:0] d, input logic [1:0] f);
    reg_wr(12'(32'h400 + 4 * i), {30'd0, f});
    reg_wr(12'(32'h800 + 8 * i), d[31:0]);
    reg_wr(12'(32'h804 + 8 * i), d[63:32]);
    exp_data[i] = d;
    exp_flg[i]  = f;
  endtask

  // Runs from the cycle after the start write; mode 0 = ready high,
  // mode 1 = ready on every third cycle. Optionally writes stop (keeping
  // loop set) in the first valid cycle where beats == stop_after.
  task automatic play(input int n_tab, input int mode, input int stop_after, input int max_cyc,
                      output int beats, output int eops, output int first, output int active);
    int e = 0;
    bit fin = 0, started = 0, stop_sent = 0;
    beats = 0; eops = 0; first = -1; active = 0;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      st_ready0 = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      ip_wreq   = 1'b0;
      if (cyc == 0) check_eq("busy_after_start", busy, 1);
      if (st_valid0) begin
        if (!started) first = cyc;
        started = 1;
        active++;
        check_eq("beat_data", st_data0, exp_data[e]);
        check_eq("beat_flags", {st_eop0, st_sop0}, exp_flg[e]);
        check_eq("busy_run", busy, 1);
        if (stop_after >= 0 && !stop_sent && beats == stop_after) begin
          ip_wreq = 1'b1; ip_wraddr = 12'h000; ip_wrdata = 32'h6;
          stop_sent = 1;
        end
        if (st_ready0) begin
          beats++;
          if (st_eop0) eops++;
          e = (e + 1) % n_tab;
        end
      end else if (started) begin
        fin = 1;
        check_eq("done_pulse", done, 1);
        check_eq("busy_in_done", busy, 0);
      end
      if (!fin) tick();
    end
    ip_wreq = 1'b0;
    check_eq("play_end", fin, 1);
  endtask

  int beats, eops, first, active;

  initial begin
    #12;
    check_eq("rst_valid", st_valid0, 0);
    check_eq("rst_outs", {busy, done, cfg_err, st_sop0, st_eop0}, 0);
    check_eq("rst_data", st_data0, 0);
    check_eq("rst_cnt", tlp_cnt, 0);
    #11 trn_rst = 1'b0;
    tick();

    // 3-entry TLP, ready high
    load_entry(0, 64'h1111_1111_1111_1111, 2'b01);
    load_entry(1, 64'h2222_2222_2222_2222, 2'b00);
    load_entry(2, 64'h3333_3333_3333_3333, 2'b10);
    reg_wr(12'h004, 32'd3);
    st_ready0 = 1'b1;
    reg_wr(12'h000, 32'h1);
    check_eq("valid_n1", st_valid0, 0);
    play(3, 0, -1, 20, beats, eops, first, active);
    check_eq("t1_first", first, 1);
    check_eq("t1_beats", beats, 3);
    check_eq("t1_active", active, 3);
    check_eq("t1_cnt", tlp_cnt, exp_cnt(1));
    tick();
    check_eq("t1_done_one_cycle", done, 0);

    // Same table, ready toggling
    reg_wr(12'h000, 32'h1);
    play(3, 1, -1, 40, beats, eops, first, active);
    check_eq("t2_beats", beats, 3);
    check_eq("t2_eops", eops, 1);
    check_eq("t2_cnt", tlp_cnt, exp_cnt(1));

    // Loop of two single-beat TLPs, stop after 10 beats
    load_entry(0, 64'hA0A0_0000_0000_00A0, 2'b11);
    load_entry(1, 64'hB0B0_0000_0000_00B1, 2'b11);
    reg_wr(12'h004, 32'd2);
    reg_wr(12'h000, 32'h3);
    play(2, 0, 10, 60, beats, eops, first, active);
    check_eq("t3_beats", beats, 12);
    check_eq("t3_gapless", active, 12);
    check_eq("t3_eops", eops, 12);
    check_eq("t3_cnt", tlp_cnt, exp_cnt(12));

    // Two-beat TLP in loop, stop while entry 0 pending
    load_entry(0, 64'hC0C0_C0C0_0000_0001, 2'b01);
    load_entry(1, 64'hD0D0_D0D0_0000_0002, 2'b10);
    reg_wr(12'h000, 32'h3);
    play(2, 0, 0, 30, beats, eops, first, active);
    check_eq("t4_beats", beats, 2);
    check_eq("t4_eops", eops, 1);
    check_eq("t4_cnt", tlp_cnt, exp_cnt(1));

    // Illegal lengths
    reg_wr(12'h004, 32'd0);
    reg_wr(12'h000, 32'h1);
    check_eq("len0_err", cfg_err, 1);
    check_eq("len0_busy", busy, 0);
    check_eq("len0_valid", st_valid0, 0);
    tick();
    check_eq("len0_err_pulse", cfg_err, 0);
    check_eq("len0_valid2", st_valid0, 0);
    reg_wr(12'h004, 32'(DEPTH + 1));
    reg_wr(12'h000, 32'h1);
    check_eq("lenbig_err", cfg_err, 1);
    check_eq("lenbig_busy", busy, 0);
    tick();
    check_eq("lenbig_valid", st_valid0, 0);
    check_eq("lenbig_busy2", busy, 0);

    // Asynchronous reset during RUN
    load_entry(0, 64'h1111_1111_1111_1111, 2'b01);
    load_entry(1, 64'h2222_2222_2222_2222, 2'b00);
    load_entry(2, 64'h3333_3333_3333_3333, 2'b10);
    reg_wr(12'h004, 32'd3);
    st_ready0 = 1'b0;
    reg_wr(12'h000, 32'h1);
    tick();
    check_eq("pre_rst_valid", st_valid0, 1);
    #2 trn_rst = 1'b1;
    #1;
    check_eq("arst_valid", st_valid0, 0);
    check_eq("arst_data", st_data0, 0);
    check_eq("arst_busy", busy, 0);
    @(negedge trn_clk);
    trn_rst = 1'b0;
    tick();
    load_entry(0, 64'h1111_1111_1111_1111, 2'b01);
    load_entry(1, 64'h2222_2222_2222_2222, 2'b00);
    load_entry(2, 64'h3333_3333_3333_3333, 2'b10);
    reg_wr(12'h004, 32'd3);
    reg_wr(12'h000, 32'h1);
    play(3, 0, -1, 20, beats, eops, first, active);
    check_eq("t6_beats", beats, 3);
    check_eq("t6_first", first, 1);
    check_eq("t6_cnt", tlp_cnt, exp_cnt(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
